odd_addr_reader: RTL and testbench
==================================

Name: odd_addr_reader

Overview:
- Read-back sequencer for a message buffer whose entries are written at odd addresses 1, 3, 5, …, 2N-1.
- Runs the other direction from the writer. It issues descending odd read addresses 2N-1, 2N-3, …, 1 to a RAM with 1-cycle read latency.
- Returned data passes through a 2-entry output FIFO with a valid/ready handshake.
- Sits between the check-node message RAM and the GF(16) variable-node update path.

Parameters:
- ADDR_W, 10, RAM address width; N ≤ 2^(ADDR_W-1).
- DATA_W, 16, RAM word width (GF16 symbol plus LLR payload).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- start  in  1  one-cycle request to begin a read-back; ignored unless the FSM is in IDLE.
- len  in  ADDR_W  entry count N, sampled on start; values > 2^(ADDR_W-1) clamp to 2^(ADDR_W-1).
- clr  in  1  synchronous abort: flushes everything and returns to IDLE; no done pulse.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address (always odd while rd_en=1).
- rd_data  in  DATA_W  RAM data, valid the cycle after rd_en.
- out_data  out  DATA_W  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when the last entry has been accepted.

Behaviour:
- Reset (reset==0, asynchronous): all of the following are forced regardless of clk:
  - state=IDLE; rd_en=0; rd_addr=0.
  - out_valid=0; out_data=0; busy=0; done=0.
  - FIFO occupancy=0; in-flight flag=0.
- Reset or clr mid-operation: discards in-flight read data. A rd_data return in the cycle after clr is not written to the FIFO.
- State IDLE:
  - start=1 with len=0: done=1 next cycle, no reads, state stays IDLE.
  - start=1 with len>0: latch N, next address A=2N-1, remaining R=N; go to ISSUE.
- State ISSUE:
  - Each cycle, rd_en=1 with rd_addr=A when credit is available. Credit is: occupancy + inflight - pop < 2, where pop = out_valid & out_ready in that cycle.
  - On issue: A=A-2, R=R-1.
  - When the issue with R==1 occurs, go to DRAIN.
  - rd_en=0 whenever there is no credit.
- State DRAIN: no reads. When occupancy==0, inflight==0 and no write is pending, pulse done=1 for one cycle and go to IDLE.
  - done coincides with the cycle after the final pop.
- Latency, start sampled at edge k:
  - rd_en=1 in cycle k+1.
  - rd_data is written into the FIFO at edge k+2.
  - out_valid=1 from cycle k+3.
- Throughput: with out_ready held high, one entry per cycle is sustained. Back-to-back rd_en for all N entries.
- FIFO rules:
  - Simultaneous push and pop keeps the occupancy unchanged.
  - Push while full cannot occur by credit construction; an assertion flags it.
  - out_data stays stable while out_valid=1 and out_ready=0.
- Order: out_data sequence = RAM[2N-1], RAM[2N-3], …, RAM[1].
- Address arithmetic: ADDR_W-bit unsigned. The last issued address is 1, so no wrap occurs; A is never decremented below 1.
- start while busy: ignored, with no effect on the current run.
- clr and start in the same cycle: clr wins; the state is IDLE on the next cycle.

Test Plan:
- Reset release, len=4, start, out_ready=1 → rd_addr 7,5,3,1 in cycles 1-4. out_data=RAM[7],RAM[5],RAM[3],RAM[1] in cycles 3-6. done in cycle 7.
- len=3, out_ready low for cycles 3-8, then high → at most 2 reads issued before stall, rd_en=0 while the FIFO is full. All 3 words are delivered in order, followed by one done pulse.
- len=0 start → done=1 next cycle, rd_en never asserted, busy stays 0.
- len=1023 (ADDR_W=10) → clamps to 512. First rd_addr=1023, last rd_addr=1, 512 outputs, 1 done.
- clr asserted in cycle 3 of a len=8 run → busy=0, out_valid=0 next cycle, no done. A following len=2 run reads addresses 3,1 correctly.
- reset driven low asynchronously mid-run (between edges) → all outputs return to reset values immediately; start with a second len pulse during busy is ignored.

Source files
------------

// File: rtl/odd_addr_reader.sv
// Read-back sequencer: issues descending odd RAM addresses 2N-1 .. 1 and
// returns the data in order through a 2-entry valid/ready output FIFO.
//
//   state | meaning
//   IDLE  | waiting for start; len==0 start produces a bare done pulse
//   ISSUE | issuing one read per cycle while FIFO credit allows
//   DRAIN | all reads issued; waiting for the FIFO and the RAM pipe to empty
module odd_addr_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              clr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(1) << (ADDR_W - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;
    logic              inflight_q;
    logic [1:0]        occ_q;
    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic              done_q;

    logic              pop, push, credit, drain_empty;
    logic              load, issue, done_set;
    logic [2:0]        credit_sum;
    logic [ADDR_W-1:0] len_c, start_addr;

    // A read issued last cycle lands in the FIFO this cycle.
    assign push        = inflight_q;
    assign pop         = out_valid & out_ready;
    assign credit_sum  = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign credit      = credit_sum < 3'd2;
    assign drain_empty = !inflight_q && ((occ_q == 2'd0) || (occ_q == 2'd1 && pop));

    // Entry count beyond the odd-address space is clamped; 2N-1 wraps cleanly in ADDR_W bits.
    assign len_c      = (len > MAX_N) ? MAX_N : len;
    assign start_addr = (len_c << 1) - ADDR_W'(1);

    assign rd_addr   = rd_en ? addr_q : '0;
    assign out_valid = occ_q != 2'd0;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign busy      = state != IDLE;
    assign done      = done_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and read-issue decode; clr overrides everything.
    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        load     = 1'b0;
        issue    = 1'b0;
        done_set = 1'b0;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_set = 1'b1;
                        end else begin
                            load     = 1'b1;
                            state_nx = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (credit) begin
                        rd_en = 1'b1;
                        issue = 1'b1;
                        if (rem_q == ADDR_W'(1)) state_nx = DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        done_set = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Address/count bookkeeping, RAM-pipe flag, output FIFO and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else if (clr) begin
            // Dropping inflight here discards the read data returning next cycle.
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            done_q     <= done_set;
            if (load) begin
                addr_q <= start_addr;
                rem_q  <= len_c;
            end else if (issue && rem_q != ADDR_W'(1)) begin
                addr_q <= addr_q - ADDR_W'(2);
                rem_q  <= rem_q - ADDR_W'(1);
            end
            if (push) begin
                mem_q[wr_ptr_q] <= rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Credit accounting guarantees the FIFO never overflows.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && occ_q == 2'd2 && !pop));

endmodule

// File: tb/tb_odd_addr_reader.sv
// Randomized bench for odd_addr_reader with a queue-based reference model.
module tb_odd_addr_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] len = '0;
    logic              clr = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              done;

    odd_addr_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .clr(clr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    // RAM with one-cycle read latency.
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected address and data sequences of the current run.
    int                exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];

    int   rel = 0, issued = 0, accepted = 0, done_cnt = 0;
    int   first_rd = -1, first_vld = -1, done_rel = -1;
    bit   done_due = 0, busy_seen = 0, hold_prev = 0, ready_rand = 0;
    logic [DATA_W-1:0] prev_data = '0;

    // Monitor: samples on the falling edge, compares against the model.
    always @(negedge clk) begin
        int pop;
        if (!reset) begin
            done_due  = 0;
            hold_prev = 0;
            issued    = 0;
            accepted  = 0;
        end else begin
            pop = (out_valid && out_ready) ? 1 : 0;
            rel++;
            if (start && !busy && !clr) begin
                rel = 0; first_rd = -1; first_vld = -1; done_rel = -1; busy_seen = 0;
            end
            if (busy) busy_seen = 1;
            if (done || done_due) check("done_time", done, done_due);
            if (done) begin
                done_cnt++;
                if (done_rel < 0) done_rel = rel;
            end
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            hold_prev = out_valid && !out_ready && !clr;
            prev_data = out_data;
            if (rd_en) begin
                if (first_rd < 0) first_rd = rel;
                check("credit", ((issued - accepted - pop) < 2) ? 1 : 0, 1);
                if (exp_addr.size() > 0) check("rd_addr", rd_addr, exp_addr.pop_front());
                else                     check("rd_extra", 1, 0);
                issued++;
            end
            if (out_valid && first_vld < 0) first_vld = rel;
            done_due = 0;
            if (pop != 0) begin
                if (exp_data.size() > 0) begin
                    check("out_data", out_data, exp_data.pop_front());
                    if (exp_data.size() == 0 && !clr) done_due = 1;
                end else begin
                    check("out_extra", 1, 0);
                end
                accepted++;
            end
            if (start && !busy && !clr && len == '0) done_due = 1;
            if (clr) begin issued = 0; accepted = 0; done_due = 0; end
        end
    end

    // Random consumer back-pressure when enabled.
    initial forever begin
        @(posedge clk);
        if (ready_rand) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_run(input int n);
        int nc;
        nc = (n > (1 << (ADDR_W-1))) ? (1 << (ADDR_W-1)) : n;
        for (int i = 0; i < nc; i++) begin
            exp_addr.push_back(2*nc - 1 - 2*i);
            exp_data.push_back(ram[2*nc - 1 - 2*i]);
        end
        @(posedge clk); #1;
        start = 1'b1;
        len   = n[ADDR_W-1:0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int c = 0;
        while (done_cnt == base && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(posedge clk);
        check(tag, done_cnt - base, 1);
        check({tag, "_empty"}, exp_data.size() + exp_addr.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},   rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_valid"},   out_valid, 0);
        check({tag, "_data"},    out_data, 0);
        check({tag, "_done"},    done, 0);
    endtask

    initial begin
        int base, iss0, n;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1 reset = 1'b1;

        // Basic len=4 run with latency checks.
        base = done_cnt;
        start_run(4);
        wait_done("len4_done", base, 50);
        check("len4_first_rd", first_rd, 1);
        check("len4_first_vld", first_vld, 3);
        check("len4_done_rel", done_rel, 7);

        // Back-pressure: consumer stalls in cycles 3..8.
        base = done_cnt;
        iss0 = issued;
        start_run(3);
        @(posedge clk); #1;
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("stall_reads", issued - iss0, 2);
        out_ready = 1'b1;
        wait_done("stall_done", base, 50);

        // len=0: bare done pulse, no reads.
        base = done_cnt;
        start_run(0);
        repeat (4) @(posedge clk);
        check("len0_done", done_cnt - base, 1);
        check("len0_done_rel", done_rel, 1);
        check("len0_no_rd", first_rd, 32'hffffffff);
        check("len0_busy", busy_seen, 0);

        // Oversized len clamps to 512 entries, random back-pressure.
        base = done_cnt;
        ready_rand = 1;
        start_run(1023);
        wait_done("clamp_done", base, 6000);
        ready_rand = 0;
        #1 out_ready = 1'b1;

        // clr in cycle 3 of a len=8 run.
        start_run(8);
        @(posedge clk); #1;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        check("clr_busy", busy, 0);
        check("clr_valid", out_valid, 0);
        base = done_cnt;
        repeat (5) @(negedge clk);
        check("clr_no_done", done_cnt - base, 0);
        base = done_cnt;
        start_run(2);
        wait_done("after_clr_done", base, 50);

        // Asynchronous reset between edges mid-run.
        start_run(6);
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Start while busy is ignored.
        base = done_cnt;
        start_run(5);
        @(posedge clk); #1 start = 1'b1; len = ADDR_W'(9);
        @(posedge clk); #1 start = 1'b0;
        wait_done("ignore_done", base, 60);
        repeat (20) @(posedge clk);
        check("ignore_no_rerun", done_cnt - base, 1);

        // Randomized runs.
        ready_rand = 1;
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(0, 40));
            base = done_cnt;
            start_run(n);
            wait_done("rand_done", base, 500);
        end
        ready_rand = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
